trap_ctrl: RTL and testbench

- Sequences machine-mode trap entry, MRET return and WFI sleep for the core.
- Sits beside the CSR file in EX.
- Decides when a pending external or timer interrupt is taken, drains and flushes the pipeline, then issues single-cycle update strobes to the CSR file (mepc, mcause, mstatus enter/exit).
- Issues PC redirects to the fetch stage.

---
 rtl/trap_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode trap sequencer beside the EX-stage CSR file.
//            Takes external/timer interrupts (drain, then CSR update and
//            redirect to mtvec), performs MRET returns and WFI sleep.
//            Optional WFI wake timeout is built when TRAP_WFI_TIMEOUT_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int WFI_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        inst_valid,
  input  logic [31:0] pc_in,
  input  logic        wfi,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        flush,
  output logic        hold_fetch,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mepc_we,
  output logic [31:0] mepc_wdata,
  output logic        mcause_we,
  output logic [31:0] mcause_wdata,
  output logic        mstatus_enter,
  output logic        mstatus_exit,
  output logic        busy
);

  localparam logic [31:0] CAUSE_EXT  = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR  = 32'h8000_0007;
  localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WFI_WAIT = 3'd1,
    S_DRAIN    = 3'd2,
    S_ENTER    = 3'd3,
    S_RETURN   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;

  logic        flush_q, flush_d;
  logic        hold_fetch_q, hold_fetch_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        mepc_we_q, mepc_we_d;
  logic [31:0] mepc_wdata_q, mepc_wdata_d;
  logic        mcause_we_q, mcause_we_d;
  logic [31:0] mcause_wdata_q, mcause_wdata_d;
  logic        mstatus_enter_q, mstatus_enter_d;
  logic        mstatus_exit_q, mstatus_exit_d;
  logic        busy_q, busy_d;

`ifdef TRAP_WFI_TIMEOUT_EN
  localparam logic [15:0] WFI_LAST = 16'(WFI_TIMEOUT - 1);
  logic [15:0] wfi_cnt_q, wfi_cnt_d;
`else
  logic [31:0] unused_wfi_timeout;
  assign unused_wfi_timeout = 32'(WFI_TIMEOUT);
`endif

  // Vector base is word aligned; the mode bits are ignored.
  logic [1:0] unused_mtvec_lo;
  assign unused_mtvec_lo = mtvec[1:0];

  logic        pend;
  logic        take;
  logic [31:0] irq_cause;

  assign pend      = (ext_irq & mie_meie) | (tmr_irq & mie_mtie);
  assign take      = pend & mstatus_mie;
  assign irq_cause = (ext_irq & mie_meie) ? CAUSE_EXT : CAUSE_TMR;

  // Next-state, latch updates and next registered outputs.
  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    drain_cnt_d      = drain_cnt_q;
`ifdef TRAP_WFI_TIMEOUT_EN
    wfi_cnt_d        = wfi_cnt_q;
`endif
    flush_d          = (state_q == S_DRAIN) || (state_q == S_ENTER) ||
                       (state_q == S_RETURN);
    hold_fetch_d     = (state_q == S_WFI_WAIT);
    busy_d           = (state_q != S_IDLE);
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    mepc_we_d        = 1'b0;
    mepc_wdata_d     = '0;
    mcause_we_d      = 1'b0;
    mcause_wdata_d   = '0;
    mstatus_enter_d  = 1'b0;
    mstatus_exit_d   = 1'b0;

    // Strobes are only produced on the non-stalled cycle that leaves a
    // state, so a stall can never duplicate a CSR update.
    if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (mret && inst_valid) begin
            state_d = S_RETURN;
          end else if (take) begin
            state_d     = S_DRAIN;
            epc_d       = pc_in;
            cause_d     = irq_cause;
            drain_cnt_d = '0;
          end else if (wfi && inst_valid) begin
            state_d = S_WFI_WAIT;
            epc_d   = pc_in + 32'd4;
`ifdef TRAP_WFI_TIMEOUT_EN
            wfi_cnt_d = '0;
`endif
          end
        end
        S_WFI_WAIT: begin
          if (pend && mstatus_mie) begin
            state_d     = S_DRAIN;
            cause_d     = irq_cause;
            drain_cnt_d = '0;
          end else if (pend) begin
            // Interrupts disabled: wake and resume after the WFI.
            state_d          = S_IDLE;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_q;
`ifdef TRAP_WFI_TIMEOUT_EN
          end else if (wfi_cnt_q == WFI_LAST) begin
            state_d          = S_IDLE;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_q;
          end else begin
            wfi_cnt_d = wfi_cnt_q + 16'd1;
`endif
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = S_ENTER;
          end else begin
            drain_cnt_d = drain_cnt_q + 4'd1;
          end
        end
        S_ENTER: begin
          state_d          = S_IDLE;
          mepc_we_d        = 1'b1;
          mepc_wdata_d     = epc_q;
          mcause_we_d      = 1'b1;
          mcause_wdata_d   = cause_q;
          mstatus_enter_d  = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = {mtvec[31:2], 2'b00};
        end
        S_RETURN: begin
          state_d          = S_IDLE;
          mstatus_exit_d   = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mepc;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      epc_q            <= '0;
      cause_q          <= '0;
      drain_cnt_q      <= '0;
`ifdef TRAP_WFI_TIMEOUT_EN
      wfi_cnt_q        <= '0;
`endif
      flush_q          <= 1'b0;
      hold_fetch_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mepc_we_q        <= 1'b0;
      mepc_wdata_q     <= '0;
      mcause_we_q      <= 1'b0;
      mcause_wdata_q   <= '0;
      mstatus_enter_q  <= 1'b0;
      mstatus_exit_q   <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      epc_q            <= epc_d;
      cause_q          <= cause_d;
      drain_cnt_q      <= drain_cnt_d;
`ifdef TRAP_WFI_TIMEOUT_EN
      wfi_cnt_q        <= wfi_cnt_d;
`endif
      flush_q          <= flush_d;
      hold_fetch_q     <= hold_fetch_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mepc_we_q        <= mepc_we_d;
      mepc_wdata_q     <= mepc_wdata_d;
      mcause_we_q      <= mcause_we_d;
      mcause_wdata_q   <= mcause_wdata_d;
      mstatus_enter_q  <= mstatus_enter_d;
      mstatus_exit_q   <= mstatus_exit_d;
      busy_q           <= busy_d;
    end
  end

  assign flush          = flush_q;
  assign hold_fetch     = hold_fetch_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mepc_we        = mepc_we_q;
  assign mepc_wdata     = mepc_wdata_q;
  assign mcause_we      = mcause_we_q;
  assign mcause_wdata   = mcause_wdata_q;
  assign mstatus_enter  = mstatus_enter_q;
  assign mstatus_exit   = mstatus_exit_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Self-checking bench for trap_ctrl: cycle model comparison plus
//            directed scenarios with literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  localparam int TB_DRAIN   = 2;
  localparam int TB_TIMEOUT = 8;
`ifdef TRAP_WFI_TIMEOUT_EN
  localparam int WFI_WAIT_CYC = 5;
`else
  localparam int WFI_WAIT_CYC = 10;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, inst_valid, wfi, mret;
  logic        ext_irq, tmr_irq, mstatus_mie, mie_meie, mie_mtie;
  logic [31:0] pc_in, mtvec, mepc;
  logic        flush, hold_fetch, redirect_valid, mepc_we, mcause_we;
  logic        mstatus_enter, mstatus_exit, busy;
  logic [31:0] redirect_pc, mepc_wdata, mcause_wdata;

  trap_ctrl #(.DRAIN_CYCLES(TB_DRAIN), .WFI_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .inst_valid(inst_valid),
    .pc_in(pc_in), .wfi(wfi), .mret(mret), .ext_irq(ext_irq),
    .tmr_irq(tmr_irq), .mstatus_mie(mstatus_mie), .mie_meie(mie_meie),
    .mie_mtie(mie_mtie), .mtvec(mtvec), .mepc(mepc), .flush(flush),
    .hold_fetch(hold_fetch), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mepc_we(mepc_we), .mepc_wdata(mepc_wdata),
    .mcause_we(mcause_we), .mcause_wdata(mcause_wdata),
    .mstatus_enter(mstatus_enter), .mstatus_exit(mstatus_exit), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        flush, hold, rv;
    logic [31:0] rpc;
    logic        mwe;
    logic [31:0] mwd;
    logic        cwe;
    logic [31:0] cwd;
    logic        ent, ext, busy;
  } outs_t;

  localparam int M_IDLE = 0, M_WFI = 1, M_DRAIN = 2, M_ENTER = 3, M_RETURN = 4;
  int          m_mode  = M_IDLE;
  int          m_left  = 0;
  int          m_age   = 0;
  logic [31:0] m_epc   = '0;
  logic [31:0] m_cause = '0;
  outs_t       exp_o   = '0;

  // Outputs for the next cycle follow from the situation this cycle.
  always @(posedge clk) begin
    outs_t       n;
    logic        m_pend;
    logic [31:0] m_sel;
    n      = '0;
    m_pend = (ext_irq & mie_meie) | (tmr_irq & mie_mtie);
    m_sel  = (ext_irq & mie_meie) ? 32'h8000_000B : 32'h8000_0007;
    if (rst) begin
      m_mode = M_IDLE; m_epc = '0; m_cause = '0;
    end else begin
      n.busy  = (m_mode != M_IDLE);
      n.hold  = (m_mode == M_WFI);
      n.flush = (m_mode == M_DRAIN) || (m_mode == M_ENTER) || (m_mode == M_RETURN);
      if (!stall) begin
        if (m_mode == M_IDLE) begin
          if (mret && inst_valid) m_mode = M_RETURN;
          else if (m_pend && mstatus_mie) begin
            m_mode = M_DRAIN; m_left = TB_DRAIN; m_epc = pc_in; m_cause = m_sel;
          end else if (wfi && inst_valid) begin
            m_mode = M_WFI; m_age = 0; m_epc = pc_in + 32'd4;
          end
        end else if (m_mode == M_WFI) begin
          if (m_pend && mstatus_mie) begin
            m_mode = M_DRAIN; m_left = TB_DRAIN; m_cause = m_sel;
          end else if (m_pend) begin
            m_mode = M_IDLE; n.rv = 1'b1; n.rpc = m_epc;
          end
`ifdef TRAP_WFI_TIMEOUT_EN
          else begin
            m_age++;
            if (m_age >= TB_TIMEOUT) begin
              m_mode = M_IDLE; n.rv = 1'b1; n.rpc = m_epc;
            end
          end
`endif
        end else if (m_mode == M_DRAIN) begin
          m_left--;
          if (m_left == 0) m_mode = M_ENTER;
        end else if (m_mode == M_ENTER) begin
          m_mode = M_IDLE;
          n.mwe = 1'b1; n.mwd = m_epc; n.cwe = 1'b1; n.cwd = m_cause;
          n.ent = 1'b1; n.rv = 1'b1; n.rpc = mtvec & ~32'd3;
        end else begin
          m_mode = M_IDLE;
          n.ext = 1'b1; n.rv = 1'b1; n.rpc = mepc;
        end
      end
    end
    exp_o = n;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("flush", flush, exp_o.flush);
      cmp("hold_fetch", hold_fetch, exp_o.hold);
      cmp("redirect_valid", redirect_valid, exp_o.rv);
      cmp("redirect_pc", redirect_pc, exp_o.rpc);
      cmp("mepc_we", mepc_we, exp_o.mwe);
      cmp("mepc_wdata", mepc_wdata, exp_o.mwd);
      cmp("mcause_we", mcause_we, exp_o.cwe);
      cmp("mcause_wdata", mcause_wdata, exp_o.cwd);
      cmp("mstatus_enter", mstatus_enter, exp_o.ent);
      cmp("mstatus_exit", mstatus_exit, exp_o.ext);
      cmp("busy", busy, exp_o.busy);
      cmp("strobe_onehot", 32'(mepc_we & mstatus_exit), 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  int cnt_hold, cnt_flush;
  bit got_strobe;

  task automatic clear_counts();
    cnt_hold = 0; cnt_flush = 0; got_strobe = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (redirect_valid === 1'b1) got_strobe = 1'b1;
    else if (!got_strobe) begin
      if (hold_fetch === 1'b1) cnt_hold++;
      if (flush === 1'b1) cnt_flush++;
    end
  endtask

  task automatic run_until(input int max);
    int i;
    i = 0;
    while (!got_strobe && i < max) begin
      tick();
      i++;
    end
    n_cmp++;
    if (!got_strobe) begin
      n_bad++;
      $display("FAIL strobe_wait: got no redirect, required one within %0d cycles", max);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; inst_valid = 0; wfi = 0; mret = 0; ext_irq = 0; tmr_irq = 0;
    mstatus_mie = 0; mie_meie = 0; mie_mtie = 0; pc_in = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; mtvec = 32'h0000_8003; mepc = '0;
    idle_inputs();
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk); rst = 0;
    cmp("reset_busy", busy, 32'd0);
    cmp("reset_flush", flush, 32'd0);
    tick(); tick();

    // 1: external interrupt taken from IDLE
    mstatus_mie = 1; mie_meie = 1; ext_irq = 1; pc_in = 32'h100; inst_valid = 1;
    clear_counts(); tick();
    ext_irq = 0; inst_valid = 0;
    run_until(20);
    cmp("t1_flush_cycles", cnt_flush, 32'd2);
    cmp("t1_mepc_we", mepc_we, 32'd1);
    cmp("t1_mepc_wdata", mepc_wdata, 32'h100);
    cmp("t1_mcause_wdata", mcause_wdata, 32'h8000_000B);
    cmp("t1_redirect_pc", redirect_pc, 32'h8000);
    cmp("t1_mstatus_enter", mstatus_enter, 32'd1);
    tick();
    cmp("t1_single_strobe", mepc_we, 32'd0);
    cmp("t1_idle_busy", busy, 32'd0);
    idle_inputs(); tick(); tick();

    // 2: WFI then timer interrupt with MIE set
    mstatus_mie = 1; mie_mtie = 1; wfi = 1; inst_valid = 1; pc_in = 32'h200;
    clear_counts(); tick();
    wfi = 0; inst_valid = 0;
    repeat (WFI_WAIT_CYC - 1) tick();
    tmr_irq = 1;
    tick();
    tmr_irq = 0;
    run_until(20);
    cmp("t2_hold_cycles", cnt_hold, 32'(WFI_WAIT_CYC));
    cmp("t2_mepc_wdata", mepc_wdata, 32'h204);
    cmp("t2_mcause_wdata", mcause_wdata, 32'h8000_0007);
    cmp("t2_mepc_we", mepc_we, 32'd1);
    idle_inputs(); tick(); tick();

    // 3: WFI woken with interrupts globally disabled
    wfi = 1; inst_valid = 1; pc_in = 32'h200;
    clear_counts(); tick();
    wfi = 0; inst_valid = 0; ext_irq = 1; mie_meie = 1;
    run_until(10);
    cmp("t3_redirect_pc", redirect_pc, 32'h204);
    cmp("t3_no_mepc_we", mepc_we, 32'd0);
    tick();
    cmp("t3_idle_busy", busy, 32'd0);
    idle_inputs(); tick(); tick();

    // 4: MRET
    mret = 1; inst_valid = 1; mepc = 32'h3000;
    clear_counts(); tick();
    mret = 0; inst_valid = 0;
    run_until(10);
    cmp("t4_mstatus_exit", mstatus_exit, 32'd1);
    cmp("t4_redirect_pc", redirect_pc, 32'h3000);
    cmp("t4_flush", flush, 32'd1);
    cmp("t4_no_enter", mstatus_enter, 32'd0);
    idle_inputs(); tick(); tick();

    // 5: both interrupts, stall during DRAIN
    mstatus_mie = 1; mie_meie = 1; mie_mtie = 1; ext_irq = 1; tmr_irq = 1;
    pc_in = 32'h500;
    clear_counts(); tick();
    ext_irq = 0; tmr_irq = 0; stall = 1;
    tick(); tick(); tick();
    stall = 0;
    run_until(20);
    cmp("t5_flush_cycles", cnt_flush, 32'd5);
    cmp("t5_mcause_wdata", mcause_wdata, 32'h8000_000B);
    cmp("t5_mepc_wdata", mepc_wdata, 32'h500);
    idle_inputs(); tick(); tick();

    // 6a: reset during the first DRAIN cycle
    mstatus_mie = 1; mie_meie = 1; ext_irq = 1; pc_in = 32'h600;
    clear_counts(); tick();
    rst = 1; ext_irq = 0;
    tick();
    cmp("t6_rst_flush", flush, 32'd0);
    cmp("t6_rst_busy", busy, 32'd0);
    rst = 0;
    clear_counts();
    repeat (6) tick();
    cmp("t6_no_strobe", 32'(got_strobe), 32'd0);
    cmp("t6_no_flush", cnt_flush, 32'd0);
    idle_inputs(); tick();

`ifdef TRAP_WFI_TIMEOUT_EN
    // 6b: WFI timeout wake
    mstatus_mie = 1; wfi = 1; inst_valid = 1; pc_in = 32'h400;
    clear_counts(); tick();
    wfi = 0; inst_valid = 0;
    run_until(30);
    cmp("t6b_hold_cycles", cnt_hold, 32'(TB_TIMEOUT - 1));
    cmp("t6b_redirect_pc", redirect_pc, 32'h404);
    cmp("t6b_no_mepc_we", mepc_we, 32'd0);
    idle_inputs(); tick(); tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
